bayer_window_3x3: RTL and testbench

Generates a 3x3 pixel neighbourhood from a raster Bayer pixel stream for the Bayer-to-RGB interpolator. It sits directly upstream of the demosaic arithmetic. It holds the two previous lines in two internal line-delay RAMs. For every input pixel it emits one window, plus the Bayer row/column parity of the window centre. Window contents outside the frame (above row 0, left of column 0) are forced to zero.

---
 rtl/bayer_window_3x3.sv | 146 ++++++++++++++
 tb/tb_bayer_window_3x3.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_window_3x3.sv
// 3x3 neighbourhood generator for a raster Bayer stream: two line-delay RAMs feed
// a 3x3 shift window, with zeroed top/left borders and centre-pixel Bayer parity.
module bayer_window_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1920,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  I_CLK,
  input  logic                  I_Rst,
  input  logic                  I_Vsync,
  input  logic                  I_De,
  input  logic [DATA_WIDTH-1:0] I_Data,
  output logic                  O_De,
  output logic                  O_Vsync,
  output logic [DATA_WIDTH-1:0] O_P11,
  output logic [DATA_WIDTH-1:0] O_P12,
  output logic [DATA_WIDTH-1:0] O_P13,
  output logic [DATA_WIDTH-1:0] O_P21,
  output logic [DATA_WIDTH-1:0] O_P22,
  output logic [DATA_WIDTH-1:0] O_P23,
  output logic [DATA_WIDTH-1:0] O_P31,
  output logic [DATA_WIDTH-1:0] O_P32,
  output logic [DATA_WIDTH-1:0] O_P33,
  output logic                  O_Row_Odd,
  output logic                  O_Col_Odd,
  output logic                  O_Line_Err
);

  localparam logic [ADDR_WIDTH-1:0] LastCol = ADDR_WIDTH'(IMG_WIDTH - 1);

  logic                  r_vs_d, r_de_d;
  logic [ADDR_WIDTH-1:0] r_col;
  logic                  r_wrap;
  logic [1:0]            r_row_cnt;
  logic                  r_row_par;
  logic [DATA_WIDTH-1:0] r_ram_a [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_ram_b [IMG_WIDTH];

  logic                  r_de_o, r_vs_o, r_err_o, r_row_odd, r_col_odd;
  logic [DATA_WIDTH-1:0] r_p11, r_p12, r_p13, r_p21, r_p22, r_p23, r_p31, r_p32, r_p33;

  logic                  w_vs_rise, w_de_fall, w_col_last, w_err, w_row_par;
  logic [ADDR_WIDTH-1:0] w_col;
  logic [1:0]            w_row_cnt;
  logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b, w_tap1, w_tap2;

  // A frame-start edge clears the counters before the coincident pixel is placed;
  // r_wrap marks that the previous pixel filled the last column of the line.
  assign w_vs_rise  = I_Vsync & ~r_vs_d;
  assign w_de_fall  = r_de_d & ~I_De;
  assign w_col      = (w_vs_rise | r_wrap) ? '0 : r_col;
  assign w_col_last = (w_col == LastCol);
  assign w_err      = I_De & r_wrap & ~w_vs_rise;
  assign w_row_cnt  = w_vs_rise ? 2'd0 : r_row_cnt;
  assign w_row_par  = w_vs_rise ? 1'b0 : r_row_par;

  assign w_rd_a = r_ram_a[w_col];
  assign w_rd_b = r_ram_b[w_col];
  assign w_tap2 = (w_row_cnt == 2'd0) ? '0 : w_rd_a;
  assign w_tap1 = (w_row_cnt == 2'd2) ? w_rd_b : '0;

  always_ff @(posedge I_CLK or posedge I_Rst) begin
    if (I_Rst) begin
      r_vs_d    <= 1'b0;
      r_de_d    <= 1'b0;
      r_col     <= '0;
      r_wrap    <= 1'b0;
      r_row_cnt <= 2'd0;
      r_row_par <= 1'b0;
    end else begin
      r_vs_d <= I_Vsync;
      r_de_d <= I_De;
      if (I_De) begin
        r_col  <= w_col_last ? '0 : w_col + ADDR_WIDTH'(1);
        r_wrap <= w_col_last;
      end else begin
        r_col  <= '0;
        r_wrap <= 1'b0;
      end
      if (w_vs_rise) begin
        r_row_cnt <= 2'd0;
        r_row_par <= 1'b0;
      end else if (w_de_fall) begin
        r_row_cnt <= (r_row_cnt == 2'd2) ? 2'd2 : r_row_cnt + 2'd1;
        r_row_par <= ~r_row_par;
      end
    end
  end

  // Line RAMs are never reset; row gating hides whatever they hold from older frames.
  always_ff @(posedge I_CLK) begin
    if (I_De) begin
      r_ram_a[w_col] <= I_Data;
      r_ram_b[w_col] <= w_rd_a;
    end
  end

  always_ff @(posedge I_CLK or posedge I_Rst) begin
    if (I_Rst) begin
      r_de_o    <= 1'b0;
      r_vs_o    <= 1'b0;
      r_err_o   <= 1'b0;
      r_row_odd <= 1'b0;
      r_col_odd <= 1'b0;
      r_p11 <= '0; r_p12 <= '0; r_p13 <= '0;
      r_p21 <= '0; r_p22 <= '0; r_p23 <= '0;
      r_p31 <= '0; r_p32 <= '0; r_p33 <= '0;
    end else begin
      r_de_o  <= I_De;
      r_vs_o  <= I_Vsync;
      r_err_o <= w_err;
      if (I_De) begin
        if (w_col == '0) begin
          r_p11 <= '0; r_p12 <= '0;
          r_p21 <= '0; r_p22 <= '0;
          r_p31 <= '0; r_p32 <= '0;
        end else begin
          r_p11 <= r_p12; r_p12 <= r_p13;
          r_p21 <= r_p22; r_p22 <= r_p23;
          r_p31 <= r_p32; r_p32 <= r_p33;
        end
        r_p13     <= w_tap1;
        r_p23     <= w_tap2;
        r_p33     <= I_Data;
        r_row_odd <= ~w_row_par;
        r_col_odd <= ~w_col[0];
      end
    end
  end

  assign O_De       = r_de_o;
  assign O_Vsync    = r_vs_o;
  assign O_Line_Err = r_err_o;
  assign O_Row_Odd  = r_row_odd;
  assign O_Col_Odd  = r_col_odd;
  assign O_P11 = r_p11;
  assign O_P12 = r_p12;
  assign O_P13 = r_p13;
  assign O_P21 = r_p21;
  assign O_P22 = r_p22;
  assign O_P23 = r_p23;
  assign O_P31 = r_p31;
  assign O_P32 = r_p32;
  assign O_P33 = r_p33;

endmodule

// File: tb/tb_bayer_window_3x3.sv
// Self-checking bench for bayer_window_3x3: a frame-array model predicts every
// window from pixel coordinates, plus literal checks on ramp, border and reset cases.
module tb_bayer_window_3x3;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int AW = 3;
  localparam int MAXR = 16;

  logic clk = 1'b0;
  logic I_Rst, I_Vsync, I_De;
  logic [DW-1:0] I_Data;
  logic O_De, O_Vsync, O_Row_Odd, O_Col_Odd, O_Line_Err;
  logic [DW-1:0] O_P11, O_P12, O_P13, O_P21, O_P22, O_P23, O_P31, O_P32, O_P33;
  logic [DW-1:0] dutWin [9];

  int testsRun = 0;
  int testsFailed = 0;
  int deHighCount = 0;
  int errCount = 0;
  bit checkEn = 0;

  logic [DW-1:0] pix [MAXR][IW];
  int  mRow, mCol;
  bit  mPrevVs, mPrevDe, mUndef;
  logic [DW-1:0] expWin [9];
  bit  expDe, expVs, expErr, expRowOdd, expColOdd, winValid;

  bayer_window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .I_CLK(clk), .I_Rst(I_Rst), .I_Vsync(I_Vsync), .I_De(I_De), .I_Data(I_Data),
    .O_De(O_De), .O_Vsync(O_Vsync),
    .O_P11(O_P11), .O_P12(O_P12), .O_P13(O_P13),
    .O_P21(O_P21), .O_P22(O_P22), .O_P23(O_P23),
    .O_P31(O_P31), .O_P32(O_P32), .O_P33(O_P33),
    .O_Row_Odd(O_Row_Odd), .O_Col_Odd(O_Col_Odd), .O_Line_Err(O_Line_Err)
  );

  always #5 clk = ~clk;

  always_comb begin
    dutWin[0] = O_P11; dutWin[1] = O_P12; dutWin[2] = O_P13;
    dutWin[3] = O_P21; dutWin[4] = O_P22; dutWin[5] = O_P23;
    dutWin[6] = O_P31; dutWin[7] = O_P32; dutWin[8] = O_P33;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mRow = 0; mCol = 0; mPrevVs = 0; mPrevDe = 0; mUndef = 0; winValid = 1;
    expDe = 0; expVs = 0; expErr = 0; expRowOdd = 0; expColOdd = 0;
    for (int k = 0; k < 9; k++) expWin[k] = '0;
  endtask

  // Window = pixels at rows r-2..r and columns c-2..c of the current frame, zero outside it.
  task automatic modelStep(input bit vs, input bit de, input logic [DW-1:0] d);
    bit vsRise;
    bit deFall;
    int c, rr, cc;
    vsRise = vs & ~mPrevVs;
    deFall = ~de & mPrevDe;
    expDe = de; expVs = vs; expErr = 0;
    if (deFall) mRow++;
    if (vsRise) begin mRow = 0; mCol = 0; mUndef = 0; end
    if (de) begin
      c = mCol;
      if (c == IW) begin c = 0; expErr = 1; mUndef = 1; end
      if (mRow < MAXR) pix[mRow][c] = d;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++) begin
          rr = mRow - 2 + dr;
          cc = c - 2 + dc;
          expWin[dr*3+dc] = (rr >= 0 && cc >= 0 && rr < MAXR) ? pix[rr][cc] : '0;
        end
      expRowOdd = (mRow % 2 == 0);
      expColOdd = (c % 2 == 0);
      mCol = c + 1;
      winValid = !mUndef;
    end else begin
      mCol = 0;
    end
    mPrevVs = vs; mPrevDe = de;
  endtask

  task automatic applyStimulus(input bit vs, input bit de, input logic [DW-1:0] d);
    I_Vsync = vs; I_De = de; I_Data = d;
    @(posedge clk);
    modelStep(vs, de, d);
    #1;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("O_De", O_De, expDe);
      checkOutput("O_Vsync", O_Vsync, expVs);
      checkOutput("O_Line_Err", O_Line_Err, expErr);
      checkOutput("O_Row_Odd", O_Row_Odd, expRowOdd);
      checkOutput("O_Col_Odd", O_Col_Odd, expColOdd);
      if (winValid)
        for (int k = 0; k < 9; k++)
          checkOutput($sformatf("P%0d%0d", k/3+1, k%3+1), dutWin[k], expWin[k]);
      if (O_De === 1'b1) deHighCount++;
      if (O_Line_Err === 1'b1) errCount++;
    end
  end

  // mode 0 random, 1 ramp 4r+c+1, 2 constant cval
  task automatic sendFrame(input int rows, input int width, input int gap, input int mode,
                           input logic [DW-1:0] cval, input bit vsWithDe);
    logic [DW-1:0] p;
    if (!vsWithDe) begin
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
    end
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < width; c++) begin
        case (mode)
          1:       p = DW'(4*r + c + 1);
          2:       p = cval;
          default: p = DW'($urandom_range(0, 255));
        endcase
        applyStimulus(vsWithDe && r == 0 && c == 0, 1, p);
        if (mode == 1 && r == 2 && c == 2) begin
          checkOutput("ramp P11", O_P11, 1);  checkOutput("ramp P12", O_P12, 2);
          checkOutput("ramp P13", O_P13, 3);  checkOutput("ramp P21", O_P21, 5);
          checkOutput("ramp P22", O_P22, 6);  checkOutput("ramp P23", O_P23, 7);
          checkOutput("ramp P31", O_P31, 9);  checkOutput("ramp P32", O_P32, 10);
          checkOutput("ramp P33", O_P33, 11);
          checkOutput("ramp RowOdd", O_Row_Odd, 1);
          checkOutput("ramp ColOdd", O_Col_Odd, 1);
        end
        if (mode == 2 && r == 0 && c == 2) begin
          checkOutput("restart r0 P13", O_P13, 0);
          checkOutput("restart r0 P23", O_P23, 0);
          checkOutput("restart r0 P33", O_P33, 8'hAA);
        end
        if (mode == 2 && r == 1 && c == 1) begin
          checkOutput("restart r1 P13", O_P13, 0);
          checkOutput("restart r1 P21", O_P21, 0);
          checkOutput("restart r1 P22", O_P22, 8'hAA);
          checkOutput("restart r1 P23", O_P23, 8'hAA);
        end
      end
      for (int g = 0; g < gap; g++) applyStimulus(0, 0, 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    I_Rst = 1; I_Vsync = 0; I_De = 0; I_Data = '0;
    for (int r = 0; r < MAXR; r++)
      for (int c = 0; c < IW; c++) pix[r][c] = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    I_Rst = 0;
    checkEn = 1;
    applyStimulus(0, 0, 0);

    $display("[TB] 4x4 ramp frame");
    deHighCount = 0;
    sendFrame(4, 4, 2, 1, 0, 0);
    checkOutput("ramp O_De count", deHighCount, 16);

    $display("[TB] frame restart to constant 0xAA");
    sendFrame(3, 6, 2, 0, 0, 0);
    sendFrame(4, 6, 2, 2, 8'hAA, 0);

    $display("[TB] back-to-back full-width lines");
    sendFrame(5, IW, 1, 0, 0, 0);

    $display("[TB] vsync coincident with first pixel");
    sendFrame(4, 5, 1, 0, 0, 1);

    $display("[TB] line overflow");
    errCount = 0;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    for (int c = 0; c < IW + 1; c++) applyStimulus(0, 1, DW'(c + 100));
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("overflow err pulses", errCount, 1);
    applyStimulus(0, 1, 8'h5C);
    checkOutput("post-overflow ColOdd", O_Col_Odd, 1);
    checkOutput("post-overflow P31", O_P31, 0);
    checkOutput("post-overflow P32", O_P32, 0);
    checkOutput("post-overflow P33", O_P33, 8'h5C);
    for (int c = 1; c < 4; c++) applyStimulus(0, 1, DW'($urandom_range(0, 255)));
    applyStimulus(0, 0, 0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++)
      sendFrame($urandom_range(1, 6), $urandom_range(1, IW), $urandom_range(1, 3), 0, 0,
                bit'($urandom_range(0, 1)));

    $display("[TB] mid-line reset");
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    for (int c = 0; c < 3; c++) applyStimulus(0, 1, DW'($urandom_range(1, 255)));
    I_Data = 8'h77;
    #2;
    I_Rst = 1;
    modelReset();
    #1;
    checkOutput("reset O_De", O_De, 0);
    checkOutput("reset O_Vsync", O_Vsync, 0);
    checkOutput("reset O_Line_Err", O_Line_Err, 0);
    checkOutput("reset O_Row_Odd", O_Row_Odd, 0);
    checkOutput("reset O_Col_Odd", O_Col_Odd, 0);
    for (int k = 0; k < 9; k++)
      checkOutput($sformatf("reset P%0d%0d", k/3+1, k%3+1), dutWin[k], 0);
    @(posedge clk);
    I_De = 0;
    @(posedge clk);
    #1;
    I_Rst = 0;
    applyStimulus(0, 0, 0);
    sendFrame(4, 6, 2, 0, 0, 0);
    applyStimulus(0, 0, 0);

    checkEn = 0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
